// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Provides the fetch FSM state encoding, the default reset PC, the fetch
// step size and a PC alignment helper.
package inst_fetch_queue_pkg;

   typedef enum logic [1:0] {
      FQ_IDLE = 2'd0,
      FQ_WAIT = 2'd1,
      FQ_DROP = 2'd2
   } fq_state_e;

   localparam logic [31:0] FQ_RESET_PC    = 32'hbfc0_0000;
   localparam int unsigned FQ_INST_BYTES  = 4;

   // Instructions are word aligned; any set low bit marks a bad fetch PC.
   function automatic logic is_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// DEPTH-entry FIFO holding packed {pc, inst, pc_err} fetch entries.
// Ports: clk, rst (sync, active-high), flush (clears contents, wins over
// push/pop), push/push_data (enqueue), pop (dequeue head), count (occupancy),
// head_valid/head_data (registered view of the entry at the read pointer).
module inst_fetch_queue_fifo
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 65
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         head_valid,
   output logic [W-1:0]                 head_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             head_valid_q, head_valid_d;
   logic [W-1:0]     head_data_q, head_data_d;

   // Next storage/pointer state; the head register looks at next-state storage
   // so an entry written into an empty FIFO is visible the following cycle.
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      head_valid_d = 1'b0;
      head_data_d  = '0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
      if (count_d != '0) begin
         head_valid_d = 1'b1;
         head_data_d  = mem_d[rd_ptr_d];
      end
   end

   // Storage needs no reset: the head is only read from slots already written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
         head_data_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
      end
   end

   assign count      = count_q;
   assign head_valid = head_valid_q;
   assign head_data  = head_data_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one instruction request at a
// time and buffers returned {pc, inst, pc_err} entries for decode.
// Ports: clk, rst (sync, active-high); redirect/redirect_pc (flush + restart);
// req_valid/req_addr/req_ready (request channel); resp_valid/resp_inst
// (returned instruction); out_valid/out_pc/out_inst/out_pc_err/out_ready
// (queue head to decode); busy (a request is outstanding).
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     INST_W   = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(FQ_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              req_valid,
   output logic [PC_W-1:0]   req_addr,
   input  logic              req_ready,
   input  logic              resp_valid,
   input  logic [INST_W-1:0] resp_inst,
   output logic              out_valid,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic              out_pc_err,
   input  logic              out_ready,
   output logic              busy
);

   localparam int unsigned ENT_W = PC_W + INST_W + 1;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   fq_state_e        state_q, state_d;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic             halted_q, halted_d;

   logic             push;
   logic [ENT_W-1:0] push_data;
   logic             pop;
   logic [CNT_W-1:0] count;
   logic             head_valid;
   logic [ENT_W-1:0] head_data;

   // Fetch FSM. A request is only issued while a slot is free, so the
   // response that ends WAIT can always be enqueued.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      halted_d   = halted_q;
      req_valid  = 1'b0;
      push       = 1'b0;
      push_data  = '0;
      case (state_q)
         FQ_IDLE: begin
            if (!redirect && !halted_q && (count < CNT_W'(DEPTH))) begin
               if (is_misaligned(fetch_pc_q[1:0])) begin
                  // Bad PC becomes an error entry; fetch stops until redirected.
                  push      = 1'b1;
                  push_data = {fetch_pc_q, {INST_W{1'b0}}, 1'b1};
                  halted_d  = 1'b1;
               end else begin
                  req_valid = !rst;
                  if (req_ready && !rst) begin
                     state_d = FQ_WAIT;
                  end
               end
            end
         end
         FQ_WAIT: begin
            if (resp_valid) begin
               state_d = FQ_IDLE;
               if (!redirect) begin
                  push       = 1'b1;
                  push_data  = {fetch_pc_q, resp_inst, 1'b0};
                  fetch_pc_d = fetch_pc_q + PC_W'(FQ_INST_BYTES);
               end
            end else if (redirect) begin
               // Response still in flight; it must be swallowed.
               state_d = FQ_DROP;
            end
         end
         FQ_DROP: begin
            if (resp_valid) begin
               state_d = FQ_IDLE;
            end
         end
         default: begin
            state_d = FQ_IDLE;
         end
      endcase
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         halted_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FQ_IDLE;
         fetch_pc_q <= RESET_PC;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         halted_q   <= halted_d;
      end
   end

   // Redirect flushes the queue and masks a same-cycle dequeue.
   assign pop = head_valid & out_ready & ~redirect;

   inst_fetch_queue_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .count      (count),
      .head_valid (head_valid),
      .head_data  (head_data)
   );

   assign req_addr   = fetch_pc_q;
   assign busy       = (state_q != FQ_IDLE);
   assign out_valid  = head_valid;
   assign out_pc     = head_data[ENT_W-1 -: PC_W];
   assign out_inst   = head_data[INST_W -: INST_W];
   assign out_pc_err = head_data[0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed scenarios plus a randomized run,
// all checked against a transaction-level model (entry queue + fetch flags).
module tb_inst_fetch_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned INST_W = 32;
   localparam logic [31:0] RST_PC = 32'hbfc0_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;
   logic              req_valid;
   logic [PC_W-1:0]   req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [INST_W-1:0] resp_inst;
   logic              out_valid;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic              out_pc_err;
   logic              out_ready;
   logic              busy;

   always #5 clk = ~clk;

   inst_fetch_queue #(
      .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_inst(resp_inst),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_pc_err(out_pc_err), .out_ready(out_ready), .busy(busy)
   );

   // Reference model: queue of entries plus fetch flags.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } ent_t;

   ent_t        q[$];
   bit          m_wait, m_drop, m_halt;
   logic [31:0] m_pc;
   int          bus_cnt = 0;  // cycles until the bus answers; 1 = answers now
   int          lat     = 1;  // response latency after accept; 0 = random 1..4
   int          total   = 0;
   int          bad     = 0;

   logic        e_req, e_busy, e_ov, e_err;
   logic [31:0] e_addr, e_pc, e_inst;

   // Apply inputs, move to the falling edge, and derive expected outputs.
   task automatic drive(input logic r, input logic rd, input logic [31:0] rpc,
                        input logic rr, input logic ordy);
      rst         = r;
      redirect    = rd;
      redirect_pc = rpc;
      req_ready   = rr;
      out_ready   = ordy;
      resp_valid  = (bus_cnt == 1);
      resp_inst   = $urandom;
      @(negedge clk);
      e_req  = !rst && !m_wait && !m_drop && !redirect && !m_halt &&
               (q.size() < DEPTH) && (m_pc[1:0] == 2'b00);
      e_addr = m_pc;
      e_busy = m_wait || m_drop;
      e_ov   = (q.size() != 0);
      e_pc   = e_ov ? q[0].pc   : 32'h0;
      e_inst = e_ov ? q[0].inst : 32'h0;
      e_err  = e_ov ? q[0].err  : 1'b0;
   endtask

   // Advance the model across the clock edge, then step the clock.
   task automatic tick();
      ent_t e;
      bit   enq;
      bit   deq;
      enq = 0;
      e.pc = 0; e.inst = 0; e.err = 0;
      if (rst) begin
         q.delete();
         m_wait = 0; m_drop = 0; m_halt = 0; m_pc = RST_PC; bus_cnt = 0;
      end else begin
         deq = (q.size() != 0) && out_ready && !redirect;
         if (bus_cnt > 0) bus_cnt--;
         if (!m_wait && !m_drop) begin
            if (!redirect && !m_halt && (q.size() < DEPTH)) begin
               if (m_pc[1:0] != 2'b00) begin
                  e.pc = m_pc; e.inst = 0; e.err = 1; enq = 1; m_halt = 1;
               end else if (req_ready) begin
                  m_wait  = 1;
                  bus_cnt = (lat == 0) ? int'($urandom_range(4, 1)) : lat;
               end
            end
         end else if (m_wait) begin
            if (resp_valid) begin
               m_wait = 0;
               if (!redirect) begin
                  e.pc = m_pc; e.inst = resp_inst; e.err = 0; enq = 1;
                  m_pc = m_pc + 32'd4;
               end
            end else if (redirect) begin
               m_wait = 0; m_drop = 1;
            end
         end else if (resp_valid) begin
            m_drop = 0;
         end
         if (redirect) begin
            m_pc = redirect_pc; m_halt = 0; q.delete();
         end else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0); tick();
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0);
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", req_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
      total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL rst_out_inst got=%h exp=0", out_inst); end
      total++; if (out_pc_err !== 1'b0) begin bad++; $display("FAIL rst_out_pc_err got=%b exp=0", out_pc_err); end
      tick();
      drive(0, 0, 0, 0, 0);
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%b exp=1", req_valid); end
      total++; if (req_addr !== RST_PC) begin bad++; $display("FAIL rst_first_addr got=%h exp=%h", req_addr, RST_PC); end
      tick();
   endtask

   task automatic test_stream();
      int n, last;
      do_reset();
      lat = 1; n = 0; last = 0;
      for (int c = 0; c < 14; c++) begin
         drive(0, 0, 0, 1, 1);
         if (out_valid === 1'b1) begin
            total++;
            if (out_pc !== RST_PC + 32'(n * 4)) begin
               bad++; $display("FAIL stream_pc got=%h exp=%h", out_pc, RST_PC + 32'(n * 4));
            end
            if (n > 0) begin
               total++;
               if (c - last != 2) begin bad++; $display("FAIL stream_gap got=%0d exp=2", c - last); end
            end
            last = c; n++;
         end
         tick();
      end
      total++; if (n != 6) begin bad++; $display("FAIL stream_count got=%0d exp=6", n); end
   endtask

   task automatic test_full();
      do_reset();
      lat = 1;
      for (int c = 0; c < 20; c++) begin drive(0, 0, 0, 1, 0); tick(); end
      drive(0, 0, 0, 1, 0);
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid got=%b exp=0", req_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy got=%b exp=0", busy); end
      total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL full_head got=%h exp=%h", out_pc, RST_PC); end
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 1);
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_drain_valid[%0d] got=%b exp=1", i, out_valid); end
         total++; if (out_pc !== RST_PC + 32'(i * 4)) begin bad++; $display("FAIL full_drain_pc[%0d] got=%h exp=%h", i, out_pc, RST_PC + 32'(i * 4)); end
         total++; if (out_inst !== e_inst) begin bad++; $display("FAIL full_drain_inst[%0d] got=%h exp=%h", i, out_inst, e_inst); end
         tick();
      end
      drive(0, 0, 0, 0, 1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", out_valid); end
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL full_resume_req got=%b exp=1", req_valid); end
      total++; if (req_addr !== RST_PC + 32'h10) begin bad++; $display("FAIL full_resume_addr got=%h exp=%h", req_addr, RST_PC + 32'h10); end
      tick();
   endtask

   task automatic test_redirect_drop();
      bit seen_resp, done;
      do_reset();
      lat = 4; seen_resp = 0; done = 0;
      drive(0, 0, 0, 1, 0);
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL drop_issue got=%b exp=1", req_valid); end
      tick();
      drive(0, 1, 32'h8000_1000, 1, 0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b exp=1", busy); end
      tick();
      for (int c = 0; c < 10 && !done; c++) begin
         drive(0, 0, 0, 1, 0);
         if (req_valid === 1'b1) begin
            done = 1;
            total++; if (req_addr !== 32'h8000_1000) begin bad++; $display("FAIL drop_addr got=%h exp=80001000", req_addr); end
            total++; if (!seen_resp) begin bad++; $display("FAIL drop_early got=req_before_resp exp=req_after_resp"); end
         end
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_stale got=%b exp=0", out_valid); end
         if (resp_valid) seen_resp = 1;
         tick();
      end
      total++; if (!done) begin bad++; $display("FAIL drop_timeout got=no_req exp=req"); end
   endtask

   task automatic test_redirect_same();
      do_reset();
      lat = 1;
      for (int c = 0; c < 5; c++) begin drive(0, 0, 0, 1, 0); tick(); end
      drive(0, 1, 32'h8000_2000, 1, 1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL same_pre_valid got=%b exp=1", out_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL same_pre_busy got=%b exp=1", busy); end
      tick();
      drive(0, 0, 0, 0, 0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL same_flush got=%b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL same_busy got=%b exp=0", busy); end
      total++; if (req_addr !== 32'h8000_2000) begin bad++; $display("FAIL same_addr got=%h exp=80002000", req_addr); end
      tick();
   endtask

   task automatic test_misaligned();
      do_reset();
      lat = 1;
      drive(0, 1, 32'h8000_0002, 0, 0); tick();
      drive(0, 0, 0, 1, 0);
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL mis_noreq got=%b exp=0", req_valid); end
      tick();
      drive(0, 0, 0, 1, 0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mis_valid got=%b exp=1", out_valid); end
      total++; if (out_pc !== 32'h8000_0002) begin bad++; $display("FAIL mis_pc got=%h exp=80000002", out_pc); end
      total++; if (out_pc_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", out_pc_err); end
      total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL mis_inst got=%h exp=0", out_inst); end
      tick();
      for (int c = 0; c < 5; c++) begin
         drive(0, 0, 0, 1, 1);
         total++; if (req_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mis_halt got=%b%b exp=00", req_valid, busy); end
         tick();
      end
      drive(0, 1, 32'h8000_0100, 1, 1); tick();
      drive(0, 0, 0, 1, 1);
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL mis_resume got=%b exp=1", req_valid); end
      total++; if (req_addr !== 32'h8000_0100) begin bad++; $display("FAIL mis_resume_addr got=%h exp=80000100", req_addr); end
      tick();
   endtask

   task automatic test_reset_mid();
      int c;
      do_reset();
      lat = 2; c = 0;
      while (!(m_wait && q.size() == 3) && c < 40) begin
         drive(0, 0, 0, 1, 0); tick(); c++;
      end
      total++; if (!(m_wait && q.size() == 3)) begin bad++; $display("FAIL rmid_setup got=%0d exp=3", q.size()); end
      drive(1, 0, 0, 1, 0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy got=%b exp=1", busy); end
      tick();
      drive(1, 0, 0, 1, 0);
      total++; if (busy !== 1'b0 || req_valid !== 1'b0) begin bad++; $display("FAIL rmid_ctrl got=%b%b exp=00", busy, req_valid); end
      total++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || out_pc_err !== 1'b0) begin
         bad++; $display("FAIL rmid_head got=%b/%h/%h/%b exp=0/0/0/0", out_valid, out_pc, out_inst, out_pc_err);
      end
      tick();
      drive(0, 0, 0, 1, 0);
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL rmid_req got=%b exp=1", req_valid); end
      total++; if (req_addr !== RST_PC) begin bad++; $display("FAIL rmid_addr got=%h exp=%h", req_addr, RST_PC); end
      tick();
   endtask

   task automatic test_random();
      logic        r, rd, rr, ordy;
      logic [31:0] rpc;
      int          sel;
      do_reset();
      lat = 0;
      for (int c = 0; c < 3000; c++) begin
         r   = ($urandom_range(299, 0) == 0);
         rd  = ($urandom_range(15, 0) == 0);
         rpc = $urandom & 32'hffff_fffc;
         sel = int'($urandom_range(9, 0));
         if (sel == 0) rpc[1:0] = 2'($urandom_range(3, 1));
         else if (sel == 1) rpc = 32'hffff_fff8;
         rr   = ($urandom_range(3, 0) != 0);
         ordy = ($urandom_range(9, 0) < 7);
         drive(r, rd, rpc, rr, ordy);
         total++; if (req_valid !== e_req) begin bad++; $display("FAIL rnd_req_valid c=%0d got=%b exp=%b", c, req_valid, e_req); end
         if (e_req) begin
            total++; if (req_addr !== e_addr) begin bad++; $display("FAIL rnd_req_addr c=%0d got=%h exp=%h", c, req_addr, e_addr); end
         end
         total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
         total++; if (out_valid !== e_ov) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, e_ov); end
         total++; if (out_pc !== e_pc) begin bad++; $display("FAIL rnd_out_pc c=%0d got=%h exp=%h", c, out_pc, e_pc); end
         total++; if (out_inst !== e_inst) begin bad++; $display("FAIL rnd_out_inst c=%0d got=%h exp=%h", c, out_inst, e_inst); end
         total++; if (out_pc_err !== e_err) begin bad++; $display("FAIL rnd_out_pc_err c=%0d got=%b exp=%b", c, out_pc_err, e_err); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; req_ready = 1'b0;
      resp_valid = 1'b0; resp_inst = '0; out_ready = 1'b0;
      m_wait = 0; m_drop = 0; m_halt = 0; m_pc = RST_PC;
      @(posedge clk);
      #1;
      test_reset();
      test_stream();
      test_full();
      test_redirect_drop();
      test_redirect_same();
      test_misaligned();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
